// File: rtl/msg_queue_wb_master_ctrl_pkg.sv
// Shared bus geometry, WISHBONE cycle-type encodings and a constant clog2 helper
// for the NIC message-queue WISHBONE master.
package msg_queue_wb_master_ctrl_pkg;

  localparam int BUS_ADDRESS_WIDTH = 32;
  localparam int BUS_DATA_WIDTH    = 32;
  localparam int GRANULARITY       = 8;
  localparam int SEL_WIDTH         = BUS_DATA_WIDTH / GRANULARITY;
  localparam int MAX_BURST_LENGHT  = 16;
  localparam int BEAT_BYTES        = BUS_DATA_WIDTH / 8;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;

  function automatic int clog2(input int value);
    clog2 = 0;
    for (int i = 0; i < 31; i++) begin
      if ((32'sd1 << i) < value) clog2 = i + 1;
    end
  endfunction

endpackage

// File: rtl/msg_queue_wb_master_ctrl_timer.sv
// Loadable down-counter, time-shared between the retry backoff delay and the
// bus watchdog of msg_queue_wb_master_ctrl.
module wb_backoff_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  input  logic         i_dec,
  output logic         o_zero
);

  logic [W-1:0] r_count;

  // Load has priority; decrement saturates at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= {W{1'b0}};
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (i_dec && (r_count != {W{1'b0}})) begin
      r_count <= r_count - {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

  assign o_zero = (r_count == {W{1'b0}});

endmodule

// File: rtl/msg_queue_wb_master_ctrl.sv
// Drains the NIC message queue onto WISHBONE as bus master (single / incrementing
// burst). Optional bus watchdog enabled by defining WB_TIMEOUT_EN.
module msg_queue_wb_master_ctrl
  import msg_queue_wb_master_ctrl_pkg::*;
#(
  parameter int N_BITS_BURST_LENGHT = clog2(MAX_BURST_LENGHT),
  parameter int RETRY_DELAY         = 4,
  parameter int TIMEOUT_CYCLES      = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           r_bus_arbitration_i,
  input  logic [BUS_ADDRESS_WIDTH-1:0]   address_i,
  input  logic [BUS_DATA_WIDTH-1:0]      data_i,
  input  logic [SEL_WIDTH-1:0]           sel_i,
  input  logic                           transaction_type_i,
  input  logic [N_BITS_BURST_LENGHT-1:0] burst_lenght_i,
  output logic                           next_data_o,
  output logic                           retry_o,
  output logic                           message_transmitted_o,
  output logic                           bus_req_o,
  input  logic                           gnt_i,
  output logic                           cyc_o,
  output logic                           stb_o,
  output logic                           we_o,
  output logic [BUS_ADDRESS_WIDTH-1:0]   adr_o,
  output logic [BUS_DATA_WIDTH-1:0]      dat_o,
  output logic [SEL_WIDTH-1:0]           sel_o,
  output logic [2:0]                     cti_o,
  input  logic                           ack_i,
  input  logic                           rty_i,
  input  logic                           err_i,
  input  logic [BUS_DATA_WIDTH-1:0]      dat_i,
  output logic [BUS_DATA_WIDTH-1:0]      rd_data_o,
  output logic                           rd_valid_o
);

  localparam int NB      = N_BITS_BURST_LENGHT;
  localparam int CNT_MAX = (RETRY_DELAY > TIMEOUT_CYCLES) ? RETRY_DELAY : TIMEOUT_CYCLES;
  localparam int CNT_W   = (clog2(CNT_MAX + 1) > 0) ? clog2(CNT_MAX + 1) : 1;
  localparam logic [CNT_W-1:0] BACKOFF_LOAD = CNT_W'((RETRY_DELAY > 0) ? RETRY_DELAY - 1 : 0);
  localparam logic [CNT_W-1:0] TIMEOUT_LOAD = CNT_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_XFER    = 2'd2,
    ST_BACKOFF = 2'd3
  } state_e;

  state_e                       r_state;
  logic [BUS_ADDRESS_WIDTH-1:0] r_base;
  logic [BUS_ADDRESS_WIDTH-1:0] r_adr;
  logic [NB-1:0]                r_len;
  logic [NB-1:0]                r_beat;
  logic                         r_type;
  logic                         r_bus_req;
  logic                         r_cyc;
  logic                         r_stb;
  logic                         r_we;
  logic [2:0]                   r_cti;
  logic [BUS_DATA_WIDTH-1:0]    r_rd_data;
  logic                         r_rd_valid;

  logic             w_in_xfer;
  logic             w_last;
  logic [NB-1:0]    w_beat_nxt;
  logic             w_err;
  logic             w_rty;
  logic             w_ack;
  logic             w_timeout;
  logic             w_retry;
  logic             w_cnt_load;
  logic [CNT_W-1:0] w_cnt_val;
  logic             w_cnt_dec;
  logic             w_cnt_zero;

  assign w_in_xfer  = (r_state == ST_XFER);
  assign w_last     = (r_beat == r_len);
  assign w_beat_nxt = r_beat + {{(NB-1){1'b0}}, 1'b1};

  // Termination priority: err > rty > ack.
  assign w_err = w_in_xfer & err_i;
  assign w_rty = w_in_xfer & ~err_i & rty_i;
  assign w_ack = w_in_xfer & ~err_i & ~rty_i & ack_i;

`ifdef WB_TIMEOUT_EN
  logic w_stall;
  assign w_stall   = w_in_xfer & ~err_i & ~rty_i & ~ack_i;
  assign w_timeout = w_stall & w_cnt_zero;
`else
  assign w_timeout = 1'b0;
`endif

  assign w_retry = w_rty | w_timeout;

  assign next_data_o           = w_ack & ~w_last;
  assign message_transmitted_o = w_err | (w_ack & w_last);
  assign retry_o               = w_retry;

  // Counter holds the backoff delay after a retry, otherwise the watchdog budget.
  always_comb begin
    w_cnt_load = 1'b0;
    w_cnt_val  = TIMEOUT_LOAD;
    w_cnt_dec  = 1'b0;
    if (w_retry) begin
      w_cnt_load = 1'b1;
      w_cnt_val  = BACKOFF_LOAD;
    end else if (((r_state == ST_REQ) && gnt_i) || w_ack || w_err) begin
      w_cnt_load = 1'b1;
    end else if (r_state == ST_BACKOFF) begin
      w_cnt_dec = ~w_cnt_zero;
`ifdef WB_TIMEOUT_EN
    end else if (w_stall) begin
      w_cnt_dec = ~w_cnt_zero;
`endif
    end else begin
      w_cnt_dec = 1'b0;
    end
  end

  wb_backoff_timer #(.W(CNT_W)) u_timer (
    .clk        (clk),
    .rst        (rst),
    .i_load     (w_cnt_load),
    .i_load_val (w_cnt_val),
    .i_dec      (w_cnt_dec),
    .o_zero     (w_cnt_zero)
  );

  // Master sequencer with all bus-side outputs registered.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= ST_IDLE;
      r_base     <= {BUS_ADDRESS_WIDTH{1'b0}};
      r_adr      <= {BUS_ADDRESS_WIDTH{1'b0}};
      r_len      <= {NB{1'b0}};
      r_beat     <= {NB{1'b0}};
      r_type     <= 1'b0;
      r_bus_req  <= 1'b0;
      r_cyc      <= 1'b0;
      r_stb      <= 1'b0;
      r_we       <= 1'b0;
      r_cti      <= CTI_CLASSIC;
      r_rd_data  <= {BUS_DATA_WIDTH{1'b0}};
      r_rd_valid <= 1'b0;
    end else begin
      if (w_ack && !r_we) begin
        r_rd_data  <= dat_i;
        r_rd_valid <= 1'b1;
      end else begin
        r_rd_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (r_bus_arbitration_i) begin
            r_base    <= address_i;
            r_type    <= transaction_type_i;
            r_len     <= burst_lenght_i;
            r_beat    <= {NB{1'b0}};
            r_bus_req <= 1'b1;
            r_state   <= ST_REQ;
          end else begin
            r_state <= ST_IDLE;
          end
        end
        ST_REQ: begin
          r_bus_req <= 1'b1;
          if (gnt_i) begin
            r_cyc   <= 1'b1;
            r_stb   <= 1'b1;
            r_we    <= r_type;
            r_adr   <= r_base;
            r_cti   <= (r_len == {NB{1'b0}}) ? CTI_CLASSIC : CTI_INCR;
            r_state <= ST_XFER;
          end else begin
            r_state <= ST_REQ;
          end
        end
        ST_XFER: begin
          if (w_err || (w_ack && w_last) || w_retry) begin
            r_cyc  <= 1'b0;
            r_stb  <= 1'b0;
            r_we   <= 1'b0;
            r_adr  <= {BUS_ADDRESS_WIDTH{1'b0}};
            r_cti  <= CTI_CLASSIC;
            r_beat <= {NB{1'b0}};
            if (!w_retry) begin
              r_bus_req <= 1'b0;
              r_state   <= ST_IDLE;
            end else if (RETRY_DELAY == 0) begin
              r_bus_req <= 1'b1;
              r_state   <= ST_REQ;
            end else begin
              r_bus_req <= 1'b0;
              r_state   <= ST_BACKOFF;
            end
          end else if (w_ack) begin
            r_beat <= w_beat_nxt;
            r_adr  <= r_adr + BUS_ADDRESS_WIDTH'(BEAT_BYTES);
            r_cti  <= (w_beat_nxt == r_len) ? CTI_END : CTI_INCR;
          end else begin
            r_state <= ST_XFER;
          end
        end
        ST_BACKOFF: begin
          if (w_cnt_zero) begin
            r_bus_req <= 1'b1;
            r_state   <= ST_REQ;
          end else begin
            r_state <= ST_BACKOFF;
          end
        end
        default: begin
          r_state   <= ST_IDLE;
          r_bus_req <= 1'b0;
          r_cyc     <= 1'b0;
          r_stb     <= 1'b0;
        end
      endcase
    end
  end

  assign bus_req_o  = r_bus_req;
  assign cyc_o      = r_cyc;
  assign stb_o      = r_stb;
  assign we_o       = r_we;
  assign adr_o      = r_adr;
  assign cti_o      = r_cti;
  assign dat_o      = r_cyc ? data_i : {BUS_DATA_WIDTH{1'b0}};
  assign sel_o      = r_cyc ? sel_i : {SEL_WIDTH{1'b0}};
  assign rd_data_o  = r_rd_data;
  assign rd_valid_o = r_rd_valid;

endmodule

// File: tb/tb_msg_queue_wb_master_ctrl.sv
// Directed self-checking bench for msg_queue_wb_master_ctrl (32-bit bus, RETRY_DELAY=4).
module tb_msg_queue_wb_master_ctrl;
  import msg_queue_wb_master_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        arb = 1'b0;
  logic [31:0] address = 32'h0;
  logic [31:0] data = 32'h0;
  logic [3:0]  sel = 4'h0;
  logic        ttype = 1'b0;
  logic [3:0]  blen = 4'h0;
  logic        gnt = 1'b0;
  logic        ack = 1'b0;
  logic        rty = 1'b0;
  logic        err = 1'b0;
  logic [31:0] sdat = 32'h0;

  logic        next_data, retry, msg_done, bus_req, cyc, stb, we, rd_valid;
  logic [31:0] adr, dat_o, rd_data;
  logic [3:0]  sel_o;
  logic [2:0]  cti;
  logic [9:0]  obs;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  msg_queue_wb_master_ctrl #(.RETRY_DELAY(4), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .rst(rst), .r_bus_arbitration_i(arb), .address_i(address),
    .data_i(data), .sel_i(sel), .transaction_type_i(ttype), .burst_lenght_i(blen),
    .next_data_o(next_data), .retry_o(retry), .message_transmitted_o(msg_done),
    .bus_req_o(bus_req), .gnt_i(gnt), .cyc_o(cyc), .stb_o(stb), .we_o(we),
    .adr_o(adr), .dat_o(dat_o), .sel_o(sel_o), .cti_o(cti), .ack_i(ack),
    .rty_i(rty), .err_i(err), .dat_i(sdat), .rd_data_o(rd_data), .rd_valid_o(rd_valid)
  );

  // {bus_req, cyc, stb, we, cti[2:0], next_data, retry, message_transmitted}
  assign obs = {bus_req, cyc, stb, we, cti, next_data, retry, msg_done};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Request, get granted, and return in the first XFER cycle with grant already dropped.
  task automatic start_msg(input logic [31:0] a, input logic t, input logic [3:0] l);
    arb = 1'b1; address = a; ttype = t; blen = l;
    tick();
    arb = 1'b0; gnt = 1'b1;
    tick();
    gnt = 1'b0;
  endtask

  task automatic test_reset();
    #3;
    n_checks++;
    if (obs !== 10'b0 || adr !== 32'h0 || rd_valid !== 1'b0 || dat_o !== 32'h0) begin
      n_errors++;
      $display("FAIL reset_outputs: obs=%b adr=%h rd_valid=%b dat_o=%h, want all zero", obs, adr, rd_valid, dat_o);
    end
    tick(); tick();
    rst = 1'b1;
    tick();
    n_checks++;
    if (obs !== 10'b0) begin
      n_errors++;
      $display("FAIL reset_idle: obs=%b want %b", obs, 10'b0);
    end
  endtask

  task automatic test_single_write();
    arb = 1'b1; address = 32'h100; ttype = 1'b1; blen = 4'd0;
    data = 32'hDEADBEEF; sel = 4'hF;
    #1;
    n_checks++;
    if (obs !== 10'b0) begin
      n_errors++; $display("FAIL single_idle: obs=%b want %b", obs, 10'b0);
    end
    tick();
    arb = 1'b0; gnt = 1'b1;
    #1;
    n_checks++;
    if (obs !== 10'b1_0_0_0_000_0_0_0) begin
      n_errors++; $display("FAIL single_req: obs=%b want %b", obs, 10'b1_0_0_0_000_0_0_0);
    end
    tick();
    gnt = 1'b0;
    #1;
    n_checks++;
    if (obs !== 10'b1_1_1_1_000_0_0_0 || adr !== 32'h100 || dat_o !== 32'hDEADBEEF || sel_o !== 4'hF) begin
      n_errors++;
      $display("FAIL single_xfer: obs=%b adr=%h dat=%h sel=%h want obs=%b adr=100 dat=deadbeef sel=f",
               obs, adr, dat_o, sel_o, 10'b1_1_1_1_000_0_0_0);
    end
    tick(); tick();
    ack = 1'b1;
    #1;
    n_checks++;
    if (obs !== 10'b1_1_1_1_000_0_0_1) begin
      n_errors++; $display("FAIL single_ack: obs=%b want %b", obs, 10'b1_1_1_1_000_0_0_1);
    end
    tick();
    ack = 1'b0;
    #1;
    n_checks++;
    if (obs !== 10'b0) begin
      n_errors++; $display("FAIL single_done: obs=%b want %b", obs, 10'b0);
    end
  endtask

  task automatic test_burst_write();
    logic [9:0] exp;
    start_msg(32'h200, 1'b1, 4'd3);
    for (int b = 0; b < 4; b++) begin
      ack = 1'b1;
      data = 32'hA0 + b;
      #1;
      exp = {4'b1111, (b == 3) ? 3'b111 : 3'b010, (b != 3), 1'b0, (b == 3)};
      n_checks++;
      if (obs !== exp || adr !== (32'h200 + 32'(4 * b)) || dat_o !== (32'hA0 + b)) begin
        n_errors++;
        $display("FAIL burst_beat%0d: obs=%b adr=%h dat=%h want obs=%b adr=%h", b, obs, adr, dat_o, exp, 32'h200 + 32'(4 * b));
      end
      tick();
    end
    ack = 1'b0;
    #1;
    n_checks++;
    if (obs !== 10'b0) begin
      n_errors++; $display("FAIL burst_done: obs=%b want %b", obs, 10'b0);
    end
  endtask

  task automatic test_retry();
    logic [9:0] exp;
    start_msg(32'h200, 1'b1, 4'd3);
    ack = 1'b1; tick(); tick();
    ack = 1'b0; rty = 1'b1;
    #1;
    n_checks++;
    if (obs !== 10'b1_1_1_1_010_0_1_0 || adr !== 32'h208) begin
      n_errors++; $display("FAIL retry_pulse: obs=%b adr=%h want %b adr=208", obs, adr, 10'b1_1_1_1_010_0_1_0);
    end
    tick();
    rty = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_checks++;
      if (obs !== 10'b0) begin
        n_errors++; $display("FAIL retry_backoff%0d: obs=%b want %b", i, obs, 10'b0);
      end
      tick();
    end
    #1;
    n_checks++;
    if (obs !== 10'b1_0_0_0_000_0_0_0) begin
      n_errors++; $display("FAIL retry_rereq: obs=%b want %b", obs, 10'b1_0_0_0_000_0_0_0);
    end
    gnt = 1'b1; tick(); gnt = 1'b0;
    for (int b = 0; b < 4; b++) begin
      ack = 1'b1;
      #1;
      exp = {4'b1111, (b == 3) ? 3'b111 : 3'b010, (b != 3), 1'b0, (b == 3)};
      n_checks++;
      if (obs !== exp || adr !== (32'h200 + 32'(4 * b))) begin
        n_errors++; $display("FAIL retry_replay%0d: obs=%b adr=%h want %b adr=%h", b, obs, adr, exp, 32'h200 + 32'(4 * b));
      end
      tick();
    end
    ack = 1'b0;
  endtask

  task automatic test_err_read();
    start_msg(32'h300, 1'b0, 4'd3);
    ack = 1'b1; sdat = 32'h11112222;
    #1;
    n_checks++;
    if (obs !== 10'b1_1_1_0_010_1_0_0) begin
      n_errors++; $display("FAIL read_beat0: obs=%b want %b", obs, 10'b1_1_1_0_010_1_0_0);
    end
    tick();
    err = 1'b1; sdat = 32'h33334444;
    #1;
    n_checks++;
    if (obs !== 10'b1_1_1_0_010_0_0_1 || adr !== 32'h304 || rd_valid !== 1'b1 || rd_data !== 32'h11112222) begin
      n_errors++;
      $display("FAIL err_beat1: obs=%b adr=%h rd_valid=%b rd_data=%h want obs=%b adr=304 rd_valid=1 rd_data=11112222",
               obs, adr, rd_valid, rd_data, 10'b1_1_1_0_010_0_0_1);
    end
    tick();
    err = 1'b0; ack = 1'b0;
    #1;
    n_checks++;
    if (obs !== 10'b0 || rd_valid !== 1'b0 || rd_data !== 32'h11112222) begin
      n_errors++; $display("FAIL err_idle: obs=%b rd_valid=%b rd_data=%h want 0 0 11112222", obs, rd_valid, rd_data);
    end
    start_msg(32'h400, 1'b1, 4'd1);
    ack = 1'b1;
    #1;
    n_checks++;
    if (obs !== 10'b1_1_1_1_010_1_0_0 || adr !== 32'h400) begin
      n_errors++; $display("FAIL after_err_b0: obs=%b adr=%h want %b adr=400", obs, adr, 10'b1_1_1_1_010_1_0_0);
    end
    tick();
    #1;
    n_checks++;
    if (obs !== 10'b1_1_1_1_111_0_0_1 || adr !== 32'h404) begin
      n_errors++; $display("FAIL after_err_b1: obs=%b adr=%h want %b adr=404", obs, adr, 10'b1_1_1_1_111_0_0_1);
    end
    tick();
    ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    start_msg(32'h500, 1'b1, 4'd3);
    ack = 1'b1; tick();
    ack = 1'b0;
    rst = 1'b0;
    #1;
    n_checks++;
    if (obs !== 10'b0) begin
      n_errors++; $display("FAIL midrst_async: obs=%b want %b", obs, 10'b0);
    end
    ack = 1'b1;
    #1;
    n_checks++;
    if (obs !== 10'b0) begin
      n_errors++; $display("FAIL midrst_ack: obs=%b want %b", obs, 10'b0);
    end
    tick(); tick();
    ack = 1'b0; rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_checks++;
      if (obs !== 10'b0 || adr !== 32'h0) begin
        n_errors++; $display("FAIL midrst_idle%0d: obs=%b adr=%h want 0", i, obs, adr);
      end
    end
  endtask

`ifdef WB_TIMEOUT_EN
  task automatic test_timeout();
    start_msg(32'h600, 1'b1, 4'd0);
    for (int i = 1; i <= 8; i++) begin
      #1;
      n_checks++;
      if (retry !== (i == 8) || cyc !== 1'b1) begin
        n_errors++; $display("FAIL timeout_stall%0d: retry=%b cyc=%b want retry=%b cyc=1", i, retry, cyc, (i == 8));
      end
      tick();
    end
    n_checks++;
    if (obs !== 10'b0) begin
      n_errors++; $display("FAIL timeout_backoff: obs=%b want %b", obs, 10'b0);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_burst_write();
    test_retry();
    test_err_read();
    test_reset_mid();
`ifdef WB_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/msg_queue_wb_master_ctrl.md
Name: msg_queue_wb_master_ctrl

Overview:
Sequencer that drains the NIC message queue onto the WISHBONE bus as bus master. Waits for a pending-message request from the queue, obtains the bus from the system arbiter, runs single or incrementing-burst cycles, and returns per-beat (next_data), retry and message-done strobes to the queue. Sits between the message queue and the WB master port of the NIC.

Parameters:
N_BITS_BURST_LENGHT, clog2(`MAX_BURST_LENGHT), width of burst length field; beats = burst_lenght_i + 1
RETRY_DELAY, 4, idle cycles after rty_i before re-requesting the bus (0 = immediate)
TIMEOUT_CYCLES, 64, cycles without ack/rty/err before abort (used only with WB_TIMEOUT_EN)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low (0 = reset)
r_bus_arbitration_i  in  1  queue has a message ready; address/data/sel/we/burst valid
address_i  in  `BUS_ADDRESS_WIDTH  message base address
data_i  in  `BUS_DATA_WIDTH  current beat write data from queue
sel_i  in  `BUS_DATA_WIDTH/`GRANULARITY  byte select
transaction_type_i  in  1  1 = write, 0 = read
burst_lenght_i  in  N_BITS_BURST_LENGHT  beats minus one
next_data_o  out  1  queue advances to next beat
retry_o  out  1  queue rewinds message to beat 0
message_transmitted_o  out  1  queue frees message
bus_req_o  out  1  request to system bus arbiter
gnt_i  in  1  bus grant
cyc_o, stb_o, we_o  out  1 each  WB CYC_O/STB_O/WE_O
adr_o  out  `BUS_ADDRESS_WIDTH  WB ADR_O
dat_o  out  `BUS_DATA_WIDTH  WB DAT_O
sel_o  out  `BUS_DATA_WIDTH/`GRANULARITY  WB SEL_O
cti_o  out  3  WB cycle type identifier
ack_i, rty_i, err_i  in  1 each  WB slave terminations
dat_i  in  `BUS_DATA_WIDTH  WB read data
rd_data_o  out  `BUS_DATA_WIDTH  captured read data
rd_valid_o  out  1  one-cycle pulse, rd_data_o valid

Behaviour:
- Reset: all outputs 0, state IDLE, beat counter 0, delay counter 0; applies immediately, including mid-cycle (cyc_o/stb_o drop without completion strobe).
- States: IDLE, REQ, XFER, BACKOFF.
- IDLE: on r_bus_arbitration_i=1 latch address_i, transaction_type_i, burst_lenght_i; go REQ next edge.
- REQ: bus_req_o=1. On gnt_i=1 go XFER next edge; cyc_o, stb_o assert in that same next cycle.
- XFER: cyc_o=stb_o=bus_req_o=1. we_o = latched type. adr_o = base + beat*(`BUS_DATA_WIDTH/8), registered, width-truncated (wraps). dat_o = data_i, sel_o = sel_i (combinational passthrough). cti_o = 3'b000 if single beat; 3'b010 for non-last beats of a burst; 3'b111 on the last beat.
- Termination priority per cycle: err_i > rty_i > ack_i.
- ack_i, not last beat: next_data_o=1 combinationally same cycle; beat+1; stay XFER with stb held. Read: rd_data_o <= dat_i, rd_valid_o pulses next cycle.
- ack_i, last beat: message_transmitted_o=1 same cycle; cyc/stb/bus_req drop next edge; go IDLE. IDLE does not re-accept r_bus_arbitration_i in the cycle of the return edge; earliest new REQ is 2 cycles after the final ack.
- rty_i: retry_o=1 same cycle; beat reset to 0; cyc/stb/bus_req drop; go BACKOFF (or REQ if RETRY_DELAY=0).
- err_i: message_transmitted_o=1 (message dropped); go IDLE.
- BACKOFF: count RETRY_DELAY cycles with bus released, then REQ.
- gnt_i deasserted during XFER: ignored (master holds bus until termination).
- Strobes next_data_o/retry_o/message_transmitted_o: mutually exclusive, never asserted outside XFER.
- r_bus_arbitration_i dropping after latch: ignored until back in IDLE.

Optional Feature:
WB_TIMEOUT_EN: defined -> watchdog counter cleared on every ack/rty/err and on XFER entry; reaching TIMEOUT_CYCLES in XFER is handled exactly as rty_i (retry_o pulse, BACKOFF). Undefined -> no counter; XFER waits indefinitely.

Decomposition:
- Bus widths, `MAX_BURST_LENGHT, CTI encodings (CTI_CLASSIC 3'b000, CTI_INCR 3'b010, CTI_END 3'b111) in NIC-defines.v; clog2 from NIC_utils.vh. State encoding local.
- One natural sub-module: wb_backoff_timer (loadable down-counter shared by BACKOFF and the watchdog).

Test Plan:
- Single write: addr 0x100, burst 0, ack 2 cycles after stb -> cti_o=000, adr_o=0x100, one message_transmitted_o pulse, no next_data_o.
- 4-beat write, 32-bit bus, addr 0x200, back-to-back acks -> adr_o 0x200/204/208/20C, cti_o 010,010,010,111, next_data_o x3, message_transmitted_o x1.
- rty_i on beat 2 of 4, RETRY_DELAY=4 -> retry_o pulse, bus released 4 cycles, restart at 0x200 beat 0, completes normally.
- err_i on beat 1 -> message_transmitted_o pulse, IDLE; next message starts clean from beat 0.
- rst driven to 0 mid-burst -> cyc_o/stb_o/bus_req_o 0 immediately, no strobes; after release idle until r_bus_arbitration_i.
- WB_TIMEOUT_EN, TIMEOUT_CYCLES=8, slave silent -> retry_o on 8th stalled cycle, BACKOFF entered.
